// File: rtl/pp_pipeline_accel_hs_pkg.sv
// rtl/pp_pipeline_accel_hs_pkg.sv - shared types and defaults for the ap_ctrl_hs caller
package pp_pipeline_accel_hs_pkg;

    localparam int DEF_RET_W = 4;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } hs_state_t;

endpackage

// File: rtl/pp_pipeline_accel_hs_watchdog.sv
// rtl/pp_pipeline_accel_hs_watchdog.sv - WAIT_DONE cycle counter with sticky timeout flag
module pp_pipeline_accel_hs_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_wait,
    output logic timeout_err
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    // Count cycles spent waiting for done; the flag latches on the limit-th cycle and never clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else if (in_wait) begin
            if (cnt == LAST) begin
                timeout_err <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/pp_pipeline_accel_hs_caller.sv
// rtl/pp_pipeline_accel_hs_caller.sv - ap_ctrl_hs initiator; optional watchdog via PP_HS_CALLER_TIMEOUT_EN
module pp_pipeline_accel_hs_caller
    import pp_pipeline_accel_hs_pkg::*;
#(
    parameter int RET_W          = DEF_RET_W,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    output logic             child_ap_start,
    input  logic             child_ap_ready,
    input  logic             child_ap_done,
    input  logic             child_ap_idle,
    output logic             child_ap_continue,
    input  logic [RET_W-1:0] child_return,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RET_W-1:0] res_data,
    output logic             busy,
    output logic [CNT_W-1:0] call_cnt,
    output logic             timeout_err
);

    hs_state_t state, next_state;
    logic      slot_free;
    logic      capture;

    // A result may land when the buffer is empty or being drained this very cycle.
    assign slot_free = !res_valid || res_ready;

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; capture also serves as the one-cycle ap_continue pulse.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) next_state = START;
            end
            START: begin
                if (child_ap_ready) begin
                    if (child_ap_done && slot_free) begin
                        capture    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_state = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (child_ap_done && slot_free) begin
                    capture    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign req_ready         = (state == IDLE);
    assign busy              = (state != IDLE);
    assign child_ap_start    = (state == START);
    assign child_ap_continue = capture;

    // Single-entry result buffer and saturating completion counter.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            call_cnt  <= '0;
        end else begin
            if (capture) begin
                res_valid <= 1'b1;
                res_data  <= child_return;
                if (call_cnt != {CNT_W{1'b1}}) call_cnt <= call_cnt + 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef PP_HS_CALLER_TIMEOUT_EN
    pp_pipeline_accel_hs_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (ap_clk),
        .rst_n      (ap_rst_n),
        .in_wait    (state == WAIT_DONE),
        .timeout_err(timeout_err)
    );

    logic unused_status;
    assign unused_status = &{1'b0, child_ap_idle};
`else
    assign timeout_err = 1'b0;

    logic unused_status;
    assign unused_status = &{1'b0, child_ap_idle, (TIMEOUT_CYCLES > 0)};
`endif

endmodule

// File: tb/tb_pp_pipeline_accel_hs_caller.sv
// tb/tb_pp_pipeline_accel_hs_caller.sv - directed self-checking bench for the ap_ctrl_hs caller
module tb_pp_pipeline_accel_hs_caller;

    localparam int RET_W = 4;
    localparam int CNT_W = 16;
    localparam int TO    = 16;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             child_ap_ready = 1'b0;
    logic             child_ap_done = 1'b0;
    logic             child_ap_idle = 1'b1;
    logic [RET_W-1:0] child_return = '0;
    logic             res_ready = 1'b0;

    logic             req_ready, child_ap_start, child_ap_continue, res_valid, busy, timeout_err;
    logic [RET_W-1:0] res_data;
    logic [CNT_W-1:0] call_cnt;

    logic             s_req_ready, s_start, s_cont, s_res_valid, s_busy, s_timeout_err;
    logic [RET_W-1:0] s_res_data;
    logic [1:0]       s_call_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    always #5 ap_clk = ~ap_clk;

    pp_pipeline_accel_hs_caller #(.RET_W(RET_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .child_ap_start(child_ap_start), .child_ap_ready(child_ap_ready), .child_ap_done(child_ap_done),
        .child_ap_idle(child_ap_idle), .child_ap_continue(child_ap_continue), .child_return(child_return),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy),
        .call_cnt(call_cnt), .timeout_err(timeout_err)
    );

    pp_pipeline_accel_hs_caller #(.RET_W(RET_W), .CNT_W(2), .TIMEOUT_CYCLES(TO)) dut_sat (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
        .child_ap_start(s_start), .child_ap_ready(child_ap_ready), .child_ap_done(child_ap_done),
        .child_ap_idle(child_ap_idle), .child_ap_continue(s_cont), .child_return(child_return),
        .res_valid(s_res_valid), .res_ready(res_ready), .res_data(s_res_data), .busy(s_busy),
        .call_cnt(s_call_cnt), .timeout_err(s_timeout_err)
    );

    task automatic cyc();
        @(posedge ap_clk);
        #2;
    endtask

    task automatic apply_reset();
        ap_rst_n = 1'b0;
        req_valid = 1'b0; child_ap_ready = 1'b0; child_ap_done = 1'b0; res_ready = 1'b0;
        repeat (2) cyc();
        ap_rst_n = 1'b1;
        cyc();
        exp_cnt = 0;
    endtask

    task automatic do_call(input logic [RET_W-1:0] ret);
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0; child_ap_ready = 1'b1; child_ap_done = 1'b1; child_return = ret;
        cyc();
        child_ap_ready = 1'b0; child_ap_done = 1'b0;
        exp_cnt++;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        #3;
        n_checks++;
        if ({req_ready, busy, child_ap_start, child_ap_continue, res_valid, timeout_err} !== 6'b100000)
            $display("FAIL reset_ctrl got %b want 100000",
                     {req_ready, busy, child_ap_start, child_ap_continue, res_valid, timeout_err});
        else n_pass++;
        n_checks++;
        if (res_data !== 4'd0 || call_cnt !== 16'd0 || s_call_cnt !== 2'd0)
            $display("FAIL reset_data got data=%h cnt=%h sat=%h want 0", res_data, call_cnt, s_call_cnt);
        else n_pass++;
        apply_reset();
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        req_valid = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || child_ap_start !== 1'b0) $display("FAIL single_c0 got rdy=%b start=%b want 1 0", req_ready, child_ap_start);
        else n_pass++;
        cyc();
        req_valid = 1'b0; child_ap_ready = 1'b1; child_ap_done = 1'b1; child_return = 4'd8;
        #1;
        n_checks++;
        if (child_ap_start !== 1'b1 || child_ap_continue !== 1'b1 || req_ready !== 1'b0)
            $display("FAIL single_c1 got start=%b cont=%b rdy=%b want 1 1 0", child_ap_start, child_ap_continue, req_ready);
        else n_pass++;
        cyc();
        child_ap_ready = 1'b0; child_ap_done = 1'b0;
        exp_cnt++;
        #1;
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 4'd8 || call_cnt !== 16'(exp_cnt) || req_ready !== 1'b1 || child_ap_start !== 1'b0)
            $display("FAIL single_c2 got v=%b d=%h cnt=%0d rdy=%b want 1 8 %0d 1", res_valid, res_data, call_cnt, req_ready, exp_cnt);
        else n_pass++;
        cyc();
        child_ap_done = 1'b1;
        #1;
        n_checks++;
        if (res_valid !== 1'b0 || child_ap_continue !== 1'b0)
            $display("FAIL spurious_done got v=%b cont=%b want 0 0", res_valid, child_ap_continue);
        else n_pass++;
        cyc();
        child_ap_done = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0 || call_cnt !== 16'(exp_cnt) || busy !== 1'b0)
            $display("FAIL spurious_nocap got v=%b cnt=%0d busy=%b want 0 %0d 0", res_valid, call_cnt, busy, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        res_ready = 1'b0;
        do_call(4'd8);
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0; child_ap_ready = 1'b1; child_ap_done = 1'b1; child_return = 4'd5;
        #1;
        n_checks++;
        if (child_ap_continue !== 1'b0) $display("FAIL bp_start_nocont got %b want 0", child_ap_continue);
        else n_pass++;
        cyc();
        child_ap_ready = 1'b0;
        repeat (2) cyc();
        n_checks++;
        if (child_ap_start !== 1'b0 || child_ap_continue !== 1'b0 || busy !== 1'b1 || res_data !== 4'd8 || res_valid !== 1'b1)
            $display("FAIL bp_hold got start=%b cont=%b busy=%b d=%h v=%b want 0 0 1 8 1",
                     child_ap_start, child_ap_continue, busy, res_data, res_valid);
        else n_pass++;
        res_ready = 1'b1;
        #1;
        n_checks++;
        if (child_ap_continue !== 1'b1) $display("FAIL bp_release got cont=%b want 1", child_ap_continue);
        else n_pass++;
        cyc();
        child_ap_done = 1'b0;
        exp_cnt++;
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 4'd5 || call_cnt !== 16'(exp_cnt) || busy !== 1'b0)
            $display("FAIL bp_second got v=%b d=%h cnt=%0d busy=%b want 1 5 %0d 0", res_valid, res_data, call_cnt, busy, exp_cnt);
        else n_pass++;
        cyc();
        n_checks++;
        if (res_valid !== 1'b0) $display("FAIL bp_drain got %b want 0", res_valid);
        else n_pass++;
    endtask

    task automatic test_delayed_child();
        res_ready = 1'b1;
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        cyc();
        n_checks++;
        if (child_ap_start !== 1'b1) $display("FAIL dly_start_held got %b want 1", child_ap_start);
        else n_pass++;
        child_ap_ready = 1'b1;
        #1;
        n_checks++;
        if (child_ap_start !== 1'b1 || child_ap_continue !== 1'b0)
            $display("FAIL dly_ready got start=%b cont=%b want 1 0", child_ap_start, child_ap_continue);
        else n_pass++;
        cyc();
        child_ap_ready = 1'b0;
        repeat (4) begin
            #1;
            n_checks++;
            if (child_ap_start !== 1'b0 || child_ap_continue !== 1'b0 || busy !== 1'b1)
                $display("FAIL dly_wait got start=%b cont=%b busy=%b want 0 0 1", child_ap_start, child_ap_continue, busy);
            else n_pass++;
            cyc();
        end
        child_ap_done = 1'b1; child_return = 4'hA;
        #1;
        n_checks++;
        if (child_ap_continue !== 1'b1) $display("FAIL dly_done_cont got %b want 1", child_ap_continue);
        else n_pass++;
        cyc();
        child_ap_done = 1'b0;
        exp_cnt++;
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 4'hA || call_cnt !== 16'(exp_cnt) || busy !== 1'b0)
            $display("FAIL dly_result got v=%b d=%h cnt=%0d busy=%b want 1 a %0d 0", res_valid, res_data, call_cnt, busy, exp_cnt);
        else n_pass++;
        cyc();
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b0;
        do_call(4'd3);
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0; child_ap_ready = 1'b1;
        cyc();
        child_ap_ready = 1'b0;
        #3;
        ap_rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res_data !== 4'd0 || call_cnt !== 16'd0 || req_ready !== 1'b1)
            $display("FAIL rst_mid got busy=%b v=%b d=%h cnt=%0d rdy=%b want 0 0 0 0 1", busy, res_valid, res_data, call_cnt, req_ready);
        else n_pass++;
        cyc();
        ap_rst_n = 1'b1;
        exp_cnt = 0;
        cyc();
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rst_release got rdy=%b busy=%b want 1 0", req_ready, busy);
        else n_pass++;
    endtask

    task automatic test_timeout();
        logic exp_late;
`ifdef PP_HS_CALLER_TIMEOUT_EN
        exp_late = 1'b1;
`else
        exp_late = 1'b0;
`endif
        res_ready = 1'b1;
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0; child_ap_ready = 1'b1;
        cyc();
        child_ap_ready = 1'b0;
        repeat (TO - 1) cyc();
        n_checks++;
        if (timeout_err !== 1'b0) $display("FAIL to_early got %b want 0", timeout_err);
        else n_pass++;
        cyc();
        n_checks++;
        if (timeout_err !== exp_late) $display("FAIL to_edge got %b want %b", timeout_err, exp_late);
        else n_pass++;
        child_ap_done = 1'b1;
        cyc();
        child_ap_done = 1'b0;
        repeat (3) cyc();
        n_checks++;
        if (timeout_err !== exp_late || busy !== 1'b0) $display("FAIL to_sticky got err=%b busy=%b want %b 0", timeout_err, busy, exp_late);
        else n_pass++;
        apply_reset();
        n_checks++;
        if (timeout_err !== 1'b0) $display("FAIL to_cleared got %b want 0", timeout_err);
        else n_pass++;
    endtask

    task automatic test_saturate();
        logic [1:0] exp_sat [5];
        exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3; exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;
        apply_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_call(4'(i + 1));
            n_checks++;
            if (s_call_cnt !== exp_sat[i] || call_cnt !== 16'(i + 1) || s_res_data !== 4'(i + 1))
                $display("FAIL sat_call%0d got sat=%0d cnt=%0d d=%h want %0d %0d %h",
                         i, s_call_cnt, call_cnt, s_res_data, exp_sat[i], i + 1, i + 1);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_delayed_child();
        test_reset_mid();
        test_timeout();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
